pe_feeder: RTL and testbench

- Job-level initiator that drives one PE_m-style 9-cell processing element.
- Accepts a job descriptor (step count, bound level, bias), streams step+1 input/weight chunks into the PE's in/weight/en port, then waits for the PE's out_en pulse.
- Returns the 8-bit saturated result on a valid/ready result channel.
- Sits between the tile buffer/controller and each PE.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_feeder_ctrl.sv | 90 +++++++++
 rtl/pe_feeder.sv | 102 ++++++++++
 tb/tb_pe_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths, FSM encoding and bound-level codes for the PE feeder and its controller.
package pe_pkg;

   localparam int CELL_BIT = 8;
   localparam int N_CELL   = 9;
   localparam int BIAS_W   = 16;
   localparam int OUT_W    = 8;
   localparam int CHUNK_W  = CELL_BIT * N_CELL;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FEED = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [2:0] BOUND_0 = 3'd0;
   localparam logic [2:0] BOUND_1 = 3'd1;
   localparam logic [2:0] BOUND_2 = 3'd2;
   localparam logic [2:0] BOUND_3 = 3'd3;
   localparam logic [2:0] BOUND_4 = 3'd4;
   localparam logic [2:0] BOUND_5 = 3'd5;

endpackage

// File: rtl/pe_feeder_ctrl.sv
// Job sequencing FSM for the PE feeder: chunk step counter and PE response timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a job descriptor
//   FEED    | accepting chunks until the one numbered step is taken
//   WAIT    | waiting for PE out_en; down-counter aborts after TIMEOUT
//   RESP    | result presented until res_ready
module pe_feeder_ctrl
   import pe_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       job_valid,
   input  logic       chunk_valid,
   input  logic       pe_out_en,
   input  logic       res_ready,
   input  logic [2:0] step,
   output logic       job_ready,
   output logic       chunk_ready,
   output logic       res_valid,
   output logic       job_take,
   output logic       chunk_take,
   output logic       first_chunk,
   output logic       res_capture,
   output logic       res_timeout,
   output logic       spurious_hit
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        step_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              last_chunk;
   logic              wait_done;

   assign last_chunk = (step_cnt == step);
   assign wait_done  = (wait_cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (job_valid)                    state_nxt = ST_FEED;
         ST_FEED: if (chunk_valid && last_chunk)    state_nxt = ST_WAIT;
         ST_WAIT: if (pe_out_en || wait_done)       state_nxt = ST_RESP;
         ST_RESP: if (res_ready)                    state_nxt = ST_IDLE;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      job_ready    = (state == ST_IDLE);
      chunk_ready  = (state == ST_FEED);
      res_valid    = (state == ST_RESP);
      job_take     = job_valid && job_ready;
      chunk_take   = chunk_valid && chunk_ready;
      first_chunk  = (step_cnt == 3'd0);
      res_capture  = (state == ST_WAIT) && pe_out_en;
      res_timeout  = (state == ST_WAIT) && !pe_out_en && wait_done;
      spurious_hit = (state != ST_WAIT) && pe_out_en;
   end

   // Timeout counter is loaded on the last accept so WAIT lasts exactly TIMEOUT cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         step_cnt <= 3'd0;
         wait_cnt <= '0;
      end else begin
         if (job_take)
            step_cnt <= 3'd0;
         else if (chunk_take)
            step_cnt <= last_chunk ? 3'd0 : step_cnt + 3'd1;

         if (chunk_take && last_chunk)
            wait_cnt <= WAIT_W'(TIMEOUT - 1);
         else if (state == ST_WAIT && !wait_done)
            wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end

endmodule

// File: rtl/pe_feeder.sv
// Job-level initiator for one 9-cell PE: streams step+1 chunks, collects the
// PE result (or a timeout) and returns it on a valid/ready channel.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [2:0]          job_step,
   input  logic [2:0]          job_bound,
   input  logic [BIAS_W-1:0]   job_bias,
   input  logic                chunk_valid,
   output logic                chunk_ready,
   input  logic [CHUNK_W-1:0]  chunk_in,
   input  logic [CHUNK_W-1:0]  chunk_w,
   output logic [CHUNK_W-1:0]  pe_in,
   output logic [CHUNK_W-1:0]  pe_weight,
   output logic [BIAS_W-1:0]   pe_bias,
   output logic [2:0]          pe_step,
   output logic [2:0]          pe_bound_level,
   output logic                pe_en,
   input  logic [OUT_W-1:0]    pe_out,
   input  logic                pe_out_en,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [OUT_W-1:0]    res_data,
   output logic                res_err,
   output logic                err_spurious
);

   logic              job_take;
   logic              chunk_take;
   logic              first_chunk;
   logic              res_capture;
   logic              res_timeout;
   logic              spurious_hit;
   logic [BIAS_W-1:0] bias_q;

   pe_feeder_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .job_valid    (job_valid),
      .chunk_valid  (chunk_valid),
      .pe_out_en    (pe_out_en),
      .res_ready    (res_ready),
      .step         (pe_step),
      .job_ready    (job_ready),
      .chunk_ready  (chunk_ready),
      .res_valid    (res_valid),
      .job_take     (job_take),
      .chunk_take   (chunk_take),
      .first_chunk  (first_chunk),
      .res_capture  (res_capture),
      .res_timeout  (res_timeout),
      .spurious_hit (spurious_hit)
   );

   // Chunk data holds across gaps; only pe_en marks a valid PE cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pe_in          <= '0;
         pe_weight      <= '0;
         pe_bias        <= '0;
         pe_step        <= 3'd0;
         pe_bound_level <= 3'd0;
         pe_en          <= 1'b0;
         bias_q         <= '0;
         res_data       <= '0;
         res_err        <= 1'b0;
         err_spurious   <= 1'b0;
      end else begin
         pe_en <= chunk_take;

         if (job_take) begin
            pe_step        <= job_step;
            pe_bound_level <= job_bound;
            bias_q         <= job_bias;
         end

         if (chunk_take) begin
            pe_in     <= chunk_in;
            pe_weight <= chunk_w;
            pe_bias   <= first_chunk ? bias_q : '0;
         end

         if (res_capture) begin
            res_data <= pe_out;
            res_err  <= 1'b0;
         end else if (res_timeout) begin
            res_data <= '0;
            res_err  <= 1'b1;
         end

         if (spurious_hit)
            err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: a hand-driven PE stub answers out_en two cycles after the last pe_en.
module tb_pe_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid;
   logic        job_ready;
   logic [2:0]  job_step;
   logic [2:0]  job_bound;
   logic [15:0] job_bias;
   logic        chunk_valid;
   logic        chunk_ready;
   logic [71:0] chunk_in;
   logic [71:0] chunk_w;
   logic [71:0] pe_in;
   logic [71:0] pe_weight;
   logic [15:0] pe_bias;
   logic [2:0]  pe_step;
   logic [2:0]  pe_bound_level;
   logic        pe_en;
   logic [7:0]  pe_out;
   logic        pe_out_en;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic        res_err;
   logic        err_spurious;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pe_feeder #(.TIMEOUT(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_step       (job_step),
      .job_bound      (job_bound),
      .job_bias       (job_bias),
      .chunk_valid    (chunk_valid),
      .chunk_ready    (chunk_ready),
      .chunk_in       (chunk_in),
      .chunk_w        (chunk_w),
      .pe_in          (pe_in),
      .pe_weight      (pe_weight),
      .pe_bias        (pe_bias),
      .pe_step        (pe_step),
      .pe_bound_level (pe_bound_level),
      .pe_en          (pe_en),
      .pe_out         (pe_out),
      .pe_out_en      (pe_out_en),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_err        (res_err),
      .err_spurious   (err_spurious)
   );

   task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [2:0] s, input logic [2:0] b, input logic [15:0] bias);
      job_valid = 1'b1;
      job_step  = s;
      job_bound = b;
      job_bias  = bias;
      tick();
      job_valid = 1'b0;
      chk("job_taken_chunk_ready", chunk_ready, 1'b1);
      chk("job_taken_pe_step", pe_step, s);
      chk("job_taken_pe_bound", pe_bound_level, b);
   endtask

   // Called in the cycle holding the last pe_en; returns with the DUT in RESP.
   task automatic pe_reply(input logic [7:0] val);
      tick();
      chk("wait_pe_en_low", pe_en, 1'b0);
      tick();
      pe_out_en = 1'b1;
      pe_out    = val;
      tick();
      pe_out_en = 1'b0;
      pe_out    = 8'h00;
   endtask

   task automatic finish_resp();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("resp_done_res_valid", res_valid, 1'b0);
      chk("resp_done_job_ready", job_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] b;
      logic [5:0] pat;
      int         acc;

      reset       = 1'b0;
      job_valid   = 1'b0;
      job_step    = 3'd0;
      job_bound   = 3'd0;
      job_bias    = 16'h0;
      chunk_valid = 1'b0;
      chunk_in    = '0;
      chunk_w     = '0;
      pe_out      = 8'h00;
      pe_out_en   = 1'b0;
      res_ready   = 1'b0;
      tick();
      tick();
      chk("rst_job_ready", job_ready, 1'b1);
      chk("rst_chunk_ready", chunk_ready, 1'b0);
      chk("rst_pe_en", pe_en, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 8'h00);
      chk("rst_err_spurious", err_spurious, 1'b0);
      reset = 1'b1;
      tick();

      // Job A: three back-to-back chunks, bias only on the first
      start_job(3'd2, 3'd1, 16'h0010);
      chunk_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b        = 8'h11 * 8'(i + 1);
         chunk_in = {9{b}};
         chunk_w  = {9{~b}};
         tick();
         chk("a_pe_en", pe_en, 1'b1);
         chk("a_pe_in", pe_in, {9{b}});
         chk("a_pe_weight", pe_weight, {9{~b}});
         chk("a_pe_bias", pe_bias, (i == 0) ? 16'h0010 : 16'h0000);
         chk("a_pe_step", pe_step, 3'd2);
         chk("a_pe_bound", pe_bound_level, 3'd1);
      end
      chunk_valid = 1'b0;
      chk("a_chunk_ready_low", chunk_ready, 1'b0);
      pe_reply(8'h5A);
      chk("a_res_valid", res_valid, 1'b1);
      chk("a_res_data", res_data, 8'h5A);
      chk("a_res_err", res_err, 1'b0);
      chk("a_job_ready_resp", job_ready, 1'b0);
      finish_resp();

      // Job B: single chunk carries the bias
      start_job(3'd0, 3'd2, 16'hFFF0);
      chunk_valid = 1'b1;
      chunk_in    = {9{8'hC3}};
      chunk_w     = {9{8'h3C}};
      tick();
      chunk_valid = 1'b0;
      chk("b_pe_en", pe_en, 1'b1);
      chk("b_pe_bias", pe_bias, 16'hFFF0);
      chk("b_chunk_ready_low", chunk_ready, 1'b0);
      pe_reply(8'h80);
      chk("b_res_valid", res_valid, 1'b1);
      chk("b_res_data", res_data, 8'h80);
      chk("b_res_err", res_err, 1'b0);
      finish_resp();

      // Job C: gapped chunks, then no PE reply -> timeout
      start_job(3'd3, 3'd3, 16'h0001);
      pat = 6'b110101;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         chunk_valid = pat[k];
         chunk_in    = {9{8'(k)}};
         tick();
         chk("c_pe_en", pe_en, pat[k]);
         if (pat[k]) acc++;
         chk("c_chunk_ready", chunk_ready, (acc == 4) ? 1'b0 : 1'b1);
      end
      chunk_valid = 1'b0;
      chk("c_last_pe_in", pe_in, {9{8'd5}});
      chk("c_pe_bias_later", pe_bias, 16'h0000);
      for (int k = 0; k < 7; k++) tick();
      chk("c_wait_res_valid_low", res_valid, 1'b0);
      tick();
      chk("c_timeout_res_valid", res_valid, 1'b1);
      chk("c_timeout_res_err", res_err, 1'b1);
      chk("c_timeout_res_data", res_data, 8'h00);

      // Stall in RESP: hold result, refuse new job, flag spurious out_en
      job_valid = 1'b1;
      job_step  = 3'd1;
      for (int k = 0; k < 5; k++) begin
         pe_out_en = (k == 2);
         pe_out    = 8'h33;
         tick();
         chk("stall_res_valid", res_valid, 1'b1);
         chk("stall_res_data", res_data, 8'h00);
         chk("stall_res_err", res_err, 1'b1);
         chk("stall_job_ready", job_ready, 1'b0);
         chk("stall_chunk_ready", chunk_ready, 1'b0);
      end
      pe_out_en = 1'b0;
      pe_out    = 8'h00;
      job_valid = 1'b0;
      chk("stall_err_spurious", err_spurious, 1'b1);
      finish_resp();
      chk("after_resp_err_spurious", err_spurious, 1'b1);
      chk("after_resp_pe_step", pe_step, 3'd3);

      // Job D aborted by reset after one chunk
      start_job(3'd2, 3'd4, 16'h0007);
      chunk_valid = 1'b1;
      chunk_in    = {9{8'hAA}};
      chunk_w     = {9{8'h55}};
      tick();
      chk("d_pe_en", pe_en, 1'b1);
      chunk_valid = 1'b0;
      reset       = 1'b0;
      tick();
      reset = 1'b1;
      chk("d_rst_pe_en", pe_en, 1'b0);
      chk("d_rst_pe_in", pe_in, 72'h0);
      chk("d_rst_pe_weight", pe_weight, 72'h0);
      chk("d_rst_pe_bias", pe_bias, 16'h0);
      chk("d_rst_pe_step", pe_step, 3'd0);
      chk("d_rst_pe_bound", pe_bound_level, 3'd0);
      chk("d_rst_chunk_ready", chunk_ready, 1'b0);
      chk("d_rst_job_ready", job_ready, 1'b1);
      chk("d_rst_res_valid", res_valid, 1'b0);
      chk("d_rst_err_spurious", err_spurious, 1'b0);

      // Job E runs cleanly after the reset
      start_job(3'd1, 3'd5, 16'h0100);
      chunk_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chunk_in = {9{8'(8'h20 + i)}};
         tick();
         chk("e_pe_en", pe_en, 1'b1);
         chk("e_pe_bias", pe_bias, (i == 0) ? 16'h0100 : 16'h0000);
         chk("e_pe_in", pe_in, {9{8'(8'h20 + i)}});
      end
      chunk_valid = 1'b0;
      pe_reply(8'h7F);
      chk("e_res_valid", res_valid, 1'b1);
      chk("e_res_data", res_data, 8'h7F);
      chk("e_res_err", res_err, 1'b0);
      chk("e_err_spurious", err_spurious, 1'b0);
      finish_resp();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
